noc16_compute_device: RTL and testbench
=======================================

Name: noc16_compute_device

Overview:
Parametrised NoC16 service endpoint. Accepts request flits on the Rx channel into a request FIFO, executes a small command set (double, accumulate, read/clear accumulator), and returns one response flit per request on the Tx channel with a full valid/ready handshake. Sits on the Ksubs3 NoC16 service port beside the GPIO/abend logic and reports a fixed design serial number.

Parameters:
DATA_W, 64, flit payload width (Rx/Tx data and accumulator)
CMD_W, 8, command field width
FIFO_DEPTH, 4, request FIFO entries; power of two, >= 2
SERIAL_NUMBER, 24'd6, value driven on designSerialNumber after reset
RESP_CMD, 8'hEF, response command for successful operations
ERR_CMD, 8'hEE, response command for unknown opcodes

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
Ksubs3_Noc16_RxData_lo  in  DATA_W  request payload
Ksubs3_Noc16_RxData_cmd  in  CMD_W  request opcode
Ksubs3_Noc16_RxData_valid  in  1  request valid
Ksubs3_Noc16_RxData_rdy  out  1  FIFO can accept
Ksubs3_Noc16_TxData_lo  out  DATA_W  response payload
Ksubs3_Noc16_TxData_cmd  out  CMD_W  response command
Ksubs3_Noc16_TxData_valid  out  1  response valid
Ksubs3_Noc16_TxData_rdy  in  1  sink accepts response
designSerialNumber  out  24  design serial number
busy  out  1  FIFO non-empty or Tx valid
err_count  out  16  saturating count of unknown opcodes

Behaviour:
- Reset (reset low, asynchronous): FIFO empty, accumulator 0, TxData_valid 0, TxData_lo 0, TxData_cmd 0, err_count 0, designSerialNumber 0, busy 0. RxData_rdy is 0 while reset is low.
- designSerialNumber loads SERIAL_NUMBER on the first clk edge after reset deasserts, then holds.
- RxData_rdy is registered. It is 1 when FIFO occupancy < FIFO_DEPTH, including the cycle after reset release.
- Push happens when RxData_valid && RxData_rdy. {cmd, lo} is written into the FIFO.
- Pop/execute happens when the FIFO is non-empty and the Tx register is free, i.e. !TxData_valid || TxData_rdy. The head entry is executed and its result loaded into the Tx register, with TxData_valid set on the same edge.
- Latency: a flit pushed at edge N is on Tx from edge N+1 at the earliest. One response per request; order is preserved.
- Tx hold: while TxData_valid && !TxData_rdy, TxData_lo and TxData_cmd stay stable. TxData_valid drops after a transfer if nothing is popped that cycle.
- Opcodes (result goes to TxData_lo; TxData_cmd = RESP_CMD unless stated):
  - 0x01 DOUBLE: lo << 1, truncated to DATA_W (MSB lost). Accumulator unchanged.
  - 0x02 ACC_ADD: acc <= acc + lo, modulo 2^DATA_W. Response is the new acc.
  - 0x03 ACC_READ: response is acc.
  - 0x04 ACC_CLEAR: acc <= 0. Response is 0.
  - Other opcodes: TxData_cmd = ERR_CMD, TxData_lo = opcode zero-extended. err_count increments, saturating at 16'hFFFF.
- Simultaneous push and pop: both occur and occupancy is unchanged. When full, rdy=0, so no push that cycle; a pop that cycle re-raises rdy on the next edge.
- Full FIFO with Tx stalled: RxData_rdy stays 0 indefinitely. No flit is lost or duplicated.
- Occupancy counter is log2(FIFO_DEPTH)+1 bits. Read and write pointers wrap modulo FIFO_DEPTH.
- busy = (occupancy != 0) || TxData_valid, registered.
- Reset mid-operation: FIFO contents and in-flight responses are discarded; no partial Tx handshake survives.

Decomposition:
- Package noc16_dev_pkg: opcode localparams OP_DOUBLE=8'h01, OP_ACC_ADD=8'h02, OP_ACC_READ=8'h03, OP_ACC_CLEAR=8'h04, and the default RESP_CMD/ERR_CMD values.
- Sub-module noc16_req_fifo: parametrised synchronous FIFO (WIDTH=CMD_W+DATA_W, DEPTH) with push/pop, full/empty and count, and the same asynchronous active-low reset.
- The execute unit and Tx register stay in the top module.

Test Plan:
- Reset release, then one request cmd=0x01, lo=21 -> designSerialNumber=6; Tx cmd=0xEF, lo=42, one cycle after the push, with TxData_rdy=1.
- ACC_ADD 5, ACC_ADD 7, ACC_READ, ACC_CLEAR, ACC_READ -> responses 5, 12, 12, 0, 0, all cmd 0xEF, in order.
- DOUBLE with lo=64'h8000_0000_0000_0001 -> lo=64'h2 (MSB truncated); ACC_ADD with acc=all-ones, lo=1 -> response 0 (wrap).
- Unknown cmd=0x7F -> Tx cmd=0xEE, lo=0x7F, err_count=1. Drive 65536 bad requests -> err_count holds 16'hFFFF.
- TxData_rdy held 0 while sending 6 requests -> one Tx pending plus 4 queued, RxData_rdy=0 and the 6th held off. Release rdy -> 6 responses in order, Tx data stable during every stall, rdy re-asserts after the first pop.
- Assert reset asynchronously mid-burst with 3 flits queued and Tx valid -> TxData_valid=0, busy=0, RxData_rdy=0 immediately. After release, first response corresponds only to new requests; accumulator reads 0.

Source files
------------

// File: rtl/noc16_dev_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc16_dev_pkg
// Description : Opcodes and default response commands for the NoC16
//               compute service endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
package noc16_dev_pkg;

  localparam logic [7:0] OP_DOUBLE    = 8'h01;
  localparam logic [7:0] OP_ACC_ADD   = 8'h02;
  localparam logic [7:0] OP_ACC_READ  = 8'h03;
  localparam logic [7:0] OP_ACC_CLEAR = 8'h04;

  localparam logic [7:0] RESP_CMD_DEF = 8'hEF;
  localparam logic [7:0] ERR_CMD_DEF  = 8'hEE;

endpackage : noc16_dev_pkg
`default_nettype wire

// File: rtl/noc16_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : noc16_req_fifo
// Description : Synchronous request FIFO with occupancy count. The head
//               entry is presented combinationally on pop_data.
// Revision    : 1.0 - initial release
// ============================================================================
module noc16_req_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : noc16_req_fifo
`default_nettype wire

// File: rtl/noc16_compute_device.sv
`default_nettype none
// ============================================================================
// Module      : noc16_compute_device
// Description : NoC16 service endpoint. Queues request flits, executes
//               double / accumulate / read / clear commands and returns one
//               response flit per request through a valid/ready Tx register.
// Revision    : 1.0 - initial release
// ============================================================================
module noc16_compute_device
  import noc16_dev_pkg::*;
#(
  parameter int                DATA_W        = 64,
  parameter int                CMD_W         = 8,
  parameter int                FIFO_DEPTH    = 4,
  parameter logic [23:0]       SERIAL_NUMBER = 24'd6,
  parameter logic [CMD_W-1:0]  RESP_CMD      = CMD_W'(RESP_CMD_DEF),
  parameter logic [CMD_W-1:0]  ERR_CMD       = CMD_W'(ERR_CMD_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Ksubs3_Noc16_RxData_lo,
  input  logic [CMD_W-1:0]  Ksubs3_Noc16_RxData_cmd,
  input  logic              Ksubs3_Noc16_RxData_valid,
  output logic              Ksubs3_Noc16_RxData_rdy,
  output logic [DATA_W-1:0] Ksubs3_Noc16_TxData_lo,
  output logic [CMD_W-1:0]  Ksubs3_Noc16_TxData_cmd,
  output logic              Ksubs3_Noc16_TxData_valid,
  input  logic              Ksubs3_Noc16_TxData_rdy,
  output logic [23:0]       designSerialNumber,
  output logic              busy,
  output logic [15:0]       err_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CMD_W+DATA_W-1:0] head;
  logic [CMD_W-1:0]        head_cmd;
  logic [DATA_W-1:0]       head_lo;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    push;
  logic                    pop;
  logic                    tx_valid_nxt;

  logic [DATA_W-1:0]       acc;
  logic [DATA_W-1:0]       acc_nxt;
  logic [DATA_W-1:0]       res_lo;
  logic [CMD_W-1:0]        res_cmd;
  logic                    is_err;

  assign push     = Ksubs3_Noc16_RxData_valid && Ksubs3_Noc16_RxData_rdy && !fifo_full;
  assign pop      = !fifo_empty && (!Ksubs3_Noc16_TxData_valid || Ksubs3_Noc16_TxData_rdy);
  assign head_cmd = head[CMD_W+DATA_W-1:DATA_W];
  assign head_lo  = head[DATA_W-1:0];

  noc16_req_fifo #(
    .WIDTH (CMD_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data ({Ksubs3_Noc16_RxData_cmd, Ksubs3_Noc16_RxData_lo}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Post-edge occupancy and Tx valid, used for the registered rdy/busy flags
  always_comb begin
    cnt_nxt = fifo_count;
    case ({push, pop})
      2'b10:   cnt_nxt = fifo_count + CNT_W'(1);
      2'b01:   cnt_nxt = fifo_count - CNT_W'(1);
      default: cnt_nxt = fifo_count;
    endcase
    if (pop) begin
      tx_valid_nxt = 1'b1;
    end else if (Ksubs3_Noc16_TxData_rdy) begin
      tx_valid_nxt = 1'b0;
    end else begin
      tx_valid_nxt = Ksubs3_Noc16_TxData_valid;
    end
  end

  // Execute unit: decode the FIFO head into a response and next accumulator
  always_comb begin
    res_cmd = RESP_CMD;
    res_lo  = '0;
    acc_nxt = acc;
    is_err  = 1'b0;
    case (head_cmd)
      CMD_W'(OP_DOUBLE): begin
        res_lo = head_lo << 1;
      end
      CMD_W'(OP_ACC_ADD): begin
        acc_nxt = acc + head_lo;
        res_lo  = acc + head_lo;
      end
      CMD_W'(OP_ACC_READ): begin
        res_lo = acc;
      end
      CMD_W'(OP_ACC_CLEAR): begin
        acc_nxt = '0;
        res_lo  = '0;
      end
      default: begin
        res_cmd = ERR_CMD;
        res_lo  = DATA_W'(head_cmd);
        is_err  = 1'b1;
      end
    endcase
  end

  // Handshake/status flags: Rx ready, Tx valid, busy and serial number
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Ksubs3_Noc16_RxData_rdy   <= 1'b0;
      Ksubs3_Noc16_TxData_valid <= 1'b0;
      busy                      <= 1'b0;
      designSerialNumber        <= '0;
    end else begin
      Ksubs3_Noc16_RxData_rdy   <= (cnt_nxt < CNT_W'(FIFO_DEPTH));
      Ksubs3_Noc16_TxData_valid <= tx_valid_nxt;
      busy                      <= (cnt_nxt != '0) || tx_valid_nxt;
      designSerialNumber        <= SERIAL_NUMBER;
    end
  end

  // Tx payload, accumulator and error counter update on each pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Ksubs3_Noc16_TxData_lo  <= '0;
      Ksubs3_Noc16_TxData_cmd <= '0;
      acc                     <= '0;
      err_count               <= '0;
    end else if (pop) begin
      Ksubs3_Noc16_TxData_lo  <= res_lo;
      Ksubs3_Noc16_TxData_cmd <= res_cmd;
      acc                     <= acc_nxt;
      if (is_err && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule : noc16_compute_device
`default_nettype wire

// File: tb/tb_noc16_compute_device.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc16_compute_device
// Description : Self-checking bench for noc16_compute_device. A queue-based
//               reference model predicts every output each cycle; directed
//               sequences pin expected responses with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc16_compute_device;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] rx_lo = '0;
  logic [7:0]  rx_cmd = '0;
  logic        rx_valid = 1'b0;
  logic        rx_rdy;
  logic [63:0] tx_lo;
  logic [7:0]  tx_cmd;
  logic        tx_valid;
  logic        tx_rdy = 1'b1;
  logic [23:0] serial;
  logic        busy;
  logic [15:0] err_count;

  int n_cmp = 0;
  int n_err = 0;

  noc16_compute_device dut (
    .clk                       (clk),
    .reset                     (reset),
    .Ksubs3_Noc16_RxData_lo    (rx_lo),
    .Ksubs3_Noc16_RxData_cmd   (rx_cmd),
    .Ksubs3_Noc16_RxData_valid (rx_valid),
    .Ksubs3_Noc16_RxData_rdy   (rx_rdy),
    .Ksubs3_Noc16_TxData_lo    (tx_lo),
    .Ksubs3_Noc16_TxData_cmd   (tx_cmd),
    .Ksubs3_Noc16_TxData_valid (tx_valid),
    .Ksubs3_Noc16_TxData_rdy   (tx_rdy),
    .designSerialNumber        (serial),
    .busy                      (busy),
    .err_count                 (err_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [71:0] m_q [$];
  logic [71:0] got [$];
  logic        m_txv = 1'b0;
  logic [7:0]  m_txc = '0;
  logic [63:0] m_txl = '0;
  logic [63:0] m_acc = '0;
  logic [15:0] m_err = '0;
  logic [23:0] m_ser = '0;
  logic        m_rdy = 1'b0;

  function void exec(input logic [7:0] c, input logic [63:0] l);
    m_txc = 8'hEF;
    case (c)
      8'h01: m_txl = {l[62:0], 1'b0};
      8'h02: begin m_acc = m_acc + l; m_txl = m_acc; end
      8'h03: m_txl = m_acc;
      8'h04: begin m_acc = '0; m_txl = '0; end
      default: begin
        m_txc = 8'hEE;
        m_txl = {56'd0, c};
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
      end
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    logic        p_push, p_pop;
    logic [71:0] e;
    if (!reset) begin
      m_q.delete();
      m_txv = 1'b0; m_txc = '0; m_txl = '0;
      m_acc = '0; m_err = '0; m_ser = '0; m_rdy = 1'b0;
    end else begin
      if (tx_valid && tx_rdy) got.push_back({tx_cmd, tx_lo});
      p_push = rx_valid && m_rdy;
      p_pop  = (m_q.size() != 0) && (!m_txv || tx_rdy);
      if (p_pop) begin
        e = m_q.pop_front();
        exec(e[71:64], e[63:0]);
        m_txv = 1'b1;
      end else if (tx_rdy) begin
        m_txv = 1'b0;
      end
      if (p_push) m_q.push_back({rx_cmd, rx_lo});
      m_rdy = (m_q.size() < 4);
      m_ser = 24'd6;
    end
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if ($time > 2) begin
      chk("rx_rdy", {71'd0, rx_rdy}, {71'd0, m_rdy});
      chk("tx_valid", {71'd0, tx_valid}, {71'd0, m_txv});
      chk("busy", {71'd0, busy}, {71'd0, (m_q.size() != 0) || m_txv});
      chk("err_count", {56'd0, err_count}, {56'd0, m_err});
      chk("serial", {48'd0, serial}, {48'd0, m_ser});
      if (m_txv) chk("tx_flit", {tx_cmd, tx_lo}, {m_txc, m_txl});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] c, input logic [63:0] l);
    logic a;
    int   g;
    rx_valid = 1'b1; rx_cmd = c; rx_lo = l; g = 0;
    do begin
      a = rx_rdy;
      @(negedge clk);
      g++;
    end while (!a && g < 200);
    chk("send_accept", {71'd0, a}, 72'd1);
    rx_valid = 1'b0;
  endtask

  task automatic chk_got(input string nm, input int i, input logic [7:0] c, input logic [63:0] l);
    if (i < got.size()) begin
      chk(nm, got[i], {c, l});
    end else begin
      n_cmp++; n_err++;
      $display("FAIL %s: response %0d missing, expected 0x%0h", nm, i, {c, l});
    end
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc_cnt, guard, r;
    #1 reset = 1'b0;
    idle(3);
    chk("reset_rdy", {71'd0, rx_rdy}, 72'd0);
    chk("reset_serial", {48'd0, serial}, 72'd0);
    reset = 1'b1;
    idle(2);
    chk("serial_after_reset", {48'd0, serial}, 72'd6);

    // single DOUBLE, response one cycle after the push edge
    send(8'h01, 64'd21);
    @(negedge clk);
    chk("double21_valid", {71'd0, tx_valid}, 72'd1);
    chk("double21_flit", {tx_cmd, tx_lo}, {8'hEF, 64'd42});
    idle(3);

    // accumulator sequence
    got.delete();
    send(8'h02, 64'd5); send(8'h02, 64'd7); send(8'h03, 64'd0);
    send(8'h04, 64'd0); send(8'h03, 64'd0);
    idle(5);
    chk_got("acc_add5", 0, 8'hEF, 64'd5);
    chk_got("acc_add7", 1, 8'hEF, 64'd12);
    chk_got("acc_read", 2, 8'hEF, 64'd12);
    chk_got("acc_clear", 3, 8'hEF, 64'd0);
    chk_got("acc_read0", 4, 8'hEF, 64'd0);

    // truncation and wrap boundaries
    got.delete();
    send(8'h01, 64'h8000_0000_0000_0001); send(8'h04, 64'd0);
    send(8'h02, 64'hFFFF_FFFF_FFFF_FFFF); send(8'h02, 64'd1);
    idle(5);
    chk_got("double_msb", 0, 8'hEF, 64'd2);
    chk_got("clear", 1, 8'hEF, 64'd0);
    chk_got("add_ones", 2, 8'hEF, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_got("add_wrap", 3, 8'hEF, 64'd0);

    // unknown opcode
    got.delete();
    send(8'h7F, 64'd0);
    idle(4);
    chk_got("bad_op", 0, 8'hEE, 64'h7F);
    chk("err_count_1", {56'd0, err_count}, 72'd1);

    // saturate the error counter
    rx_valid = 1'b1; rx_cmd = 8'h80; rx_lo = '0;
    acc_cnt = 0; guard = 0;
    while (acc_cnt < 65536 && guard < 70000) begin
      if (rx_rdy) acc_cnt++;
      @(negedge clk);
      guard++;
    end
    rx_valid = 1'b0;
    chk("err_burst_accepted", 72'(acc_cnt), 72'd65536);
    idle(6);
    chk("err_saturated", {56'd0, err_count}, 72'hFFFF);

    // stalled Tx: one pending plus four queued, sixth held off
    tx_rdy = 1'b0;
    idle(2);
    got.delete();
    for (int i = 1; i <= 5; i++) send(8'h01, 64'(i));
    chk("stall_rdy_low", {71'd0, rx_rdy}, 72'd0);
    rx_valid = 1'b1; rx_cmd = 8'h01; rx_lo = 64'd6;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold_rdy", {71'd0, rx_rdy}, 72'd0);
      chk("stall_hold_flit", {tx_cmd, tx_lo}, {8'hEF, 64'd2});
    end
    tx_rdy = 1'b1;
    @(negedge clk);
    chk("stall_rdy_reassert", {71'd0, rx_rdy}, 72'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    idle(10);
    chk("stall_count", 72'(got.size()), 72'd6);
    for (int i = 0; i < 6; i++) chk_got("stall_order", i, 8'hEF, 64'(2 * (i + 1)));

    // randomized traffic with backpressure
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      rx_valid = $urandom_range(0, 1) == 1;
      case (r)
        0, 1:    rx_cmd = 8'h01;
        2, 3, 4: rx_cmd = 8'h02;
        5, 7:    rx_cmd = 8'h03;
        6:       rx_cmd = 8'h04;
        8:       rx_cmd = 8'($urandom);
        default: rx_cmd = 8'h00;
      endcase
      rx_lo  = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      tx_rdy = $urandom_range(0, 3) != 0;
      @(negedge clk);
    end
    rx_valid = 1'b0; tx_rdy = 1'b1;
    idle(8);

    // asynchronous reset mid-burst
    tx_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h02, 64'd3);
    #2 reset = 1'b0;
    #1;
    chk("areset_tx_valid", {71'd0, tx_valid}, 72'd0);
    chk("areset_busy", {71'd0, busy}, 72'd0);
    chk("areset_rdy", {71'd0, rx_rdy}, 72'd0);
    chk("areset_tx_lo", {8'd0, tx_lo}, 72'd0);
    idle(3);
    reset = 1'b1;
    got.delete();
    tx_rdy = 1'b1;
    send(8'h03, 64'd0);
    idle(5);
    chk("after_reset_count", 72'(got.size()), 72'd1);
    chk_got("after_reset_acc", 0, 8'hEF, 64'd0);
    chk("after_reset_err", {56'd0, err_count}, 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_noc16_compute_device
`default_nettype wire
